// File: rtl/topology_sequencer_if.sv
// Bundles the instruction-RAM read port and the layer-datapath command
// handshake driven by topology_sequencer.
interface topology_sequencer_if;
  logic [7:0] instr_addr;
  logic       instr_en;
  logic [7:0] instr_data;
  logic       layer_start;
  logic [7:0] layer_in_size;
  logic [7:0] layer_out_size;
  logic [7:0] layer_index;
  logic       layer_done;

  modport master (
    output instr_addr, instr_en,
    output layer_start, layer_in_size, layer_out_size, layer_index,
    input  instr_data, layer_done
  );

  modport slave (
    input  instr_addr, instr_en,
    input  layer_start, layer_in_size, layer_out_size, layer_index,
    output instr_data, layer_done
  );
endinterface

// File: rtl/topology_sequencer.sv
// Walks the topology program in instruction RAM and issues one layer command
// per adjacent pair of neuron-count entries, stopping at the end marker.
module topology_sequencer #(
  parameter logic [7:0] END_MARKER = 8'hFF,
  parameter logic [7:0] MAX_ADDR   = 8'd127
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  topology_sequencer_if.master        bus,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_IN,
    FETCH_OUT,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  state_t     state, state_n;
  logic [7:0] addr_q, addr_n;
  logic [7:0] in_q, in_n;
  logic [7:0] out_q, out_n;
  logic [7:0] idx_q, idx_n;
  logic       error_q, error_n;
  logic       layer_start_q;
  logic       done_q;

  // State and datapath registers; the command and done pulses are registered
  // from the next state so they line up exactly with ISSUE and FINISH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      addr_q        <= 8'd0;
      in_q          <= 8'd0;
      out_q         <= 8'd0;
      idx_q         <= 8'd0;
      error_q       <= 1'b0;
      layer_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state         <= state_n;
      addr_q        <= addr_n;
      in_q          <= in_n;
      out_q         <= out_n;
      idx_q         <= idx_n;
      error_q       <= error_n;
      layer_start_q <= (state_n == ISSUE);
      done_q        <= (state_n == FINISH);
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    in_n    = in_q;
    out_n   = out_q;
    idx_n   = idx_q;
    error_n = error_q;
    case (state)
      IDLE: begin
        if (start) begin
          error_n = 1'b0;
          addr_n  = 8'd0;
          idx_n   = 8'd0;
          state_n = FETCH_IN;
        end
      end
      FETCH_IN: begin
        if (bus.instr_data == END_MARKER || bus.instr_data == 8'd0 ||
            addr_q == MAX_ADDR) begin
          error_n = 1'b1;
          state_n = FINISH;
        end else begin
          in_n    = bus.instr_data;
          addr_n  = addr_q + 8'd1;
          state_n = FETCH_OUT;
        end
      end
      FETCH_OUT: begin
        // A marker right after the first entry means no layer can be formed.
        if (bus.instr_data == END_MARKER) begin
          if (idx_q == 8'd0) error_n = 1'b1;
          state_n = FINISH;
        end else if (bus.instr_data == 8'd0) begin
          error_n = 1'b1;
          state_n = FINISH;
        end else begin
          out_n   = bus.instr_data;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (bus.layer_done) begin
          in_n  = out_q;
          idx_n = idx_q + 8'd1;
          if (addr_q == MAX_ADDR) begin
            error_n = 1'b1;
            state_n = FINISH;
          end else begin
            addr_n  = addr_q + 8'd1;
            state_n = FETCH_OUT;
          end
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.instr_addr     = addr_q;
  assign bus.instr_en       = (state == FETCH_IN) || (state == FETCH_OUT);
  assign bus.layer_start    = layer_start_q;
  assign bus.layer_in_size  = in_q;
  assign bus.layer_out_size = out_q;
  assign bus.layer_index    = idx_q;
  assign busy               = (state != IDLE);
  assign done               = done_q;
  assign error              = error_q;

endmodule

// File: tb/tb_topology_sequencer.sv
// Directed bench for topology_sequencer: a behavioural RAM, a datapath that
// can answer layer_start automatically, and a monitor logging commands/done.
module tb_topology_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, error;
  logic [7:0] ram [0:127];
  logic       auto_en = 1'b0;
  logic       auto_done = 1'b0;
  logic       manual_done = 1'b0;
  int         pend = 0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         e0 = 0;
  int         ls_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] ls_in  [0:255];
  logic [7:0] ls_out [0:255];
  logic [7:0] ls_idx [0:255];
  int         ls_cyc [0:255];
  int         done_cyc = 0;
  logic       err_at_done = 1'b0;
  logic [7:0] addr_at_done = 8'd0;

  topology_sequencer_if bus();

  topology_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign bus.instr_data = bus.instr_en ? ram[bus.instr_addr[6:0]] : 8'h00;
  assign bus.layer_done = auto_done | manual_done;

  // Datapath stand-in: answers each layer_start with layer_done two cycles later.
  always @(negedge clk) begin
    auto_done = 1'b0;
    if (reset || !auto_en) begin
      pend = 0;
    end else if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) auto_done = 1'b1;
    end else if (bus.layer_start) begin
      pend = 2;
    end
  end

  always @(negedge clk) begin
    if (bus.layer_start && ls_cnt < 256) begin
      ls_in[ls_cnt]  = bus.layer_in_size;
      ls_out[ls_cnt] = bus.layer_out_size;
      ls_idx[ls_cnt] = bus.layer_index;
      ls_cyc[ls_cnt] = cyc;
      ls_cnt = ls_cnt + 1;
    end
    if (done) begin
      done_cnt     = done_cnt + 1;
      done_cyc     = cyc;
      err_at_done  = error;
      addr_at_done = bus.instr_addr;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected) else begin
      errors = errors + 1;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_addr"},      32'(bus.instr_addr), 0);
    check_output({tag, "_en"},        32'(bus.instr_en), 0);
    check_output({tag, "_lstart"},    32'(bus.layer_start), 0);
    check_output({tag, "_in_size"},   32'(bus.layer_in_size), 0);
    check_output({tag, "_out_size"},  32'(bus.layer_out_size), 0);
    check_output({tag, "_index"},     32'(bus.layer_index), 0);
    check_output({tag, "_busy"},      32'(busy), 0);
    check_output({tag, "_done"},      32'(done), 0);
    check_output({tag, "_error"},     32'(error), 0);
  endtask

  // Pulses start for one edge; on return the bench sits in cycle 1.
  task automatic apply_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < budget) begin
      tick();
      n = n + 1;
    end
    check_output({tag, "_done_seen"}, 32'(done_cnt - base), 1);
  endtask

  task automatic wait_layer_start(input string tag, input int budget);
    int n;
    n = 0;
    while (!bus.layer_start && n < budget) begin
      tick();
      n = n + 1;
    end
    check_output({tag, "_lstart_seen"}, 32'(bus.layer_start), 1);
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 128; i++) ram[i] = 8'h00;
  endtask

  initial begin
    int base;
    int dbase;

    clear_ram();
    repeat (2) tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();
    check_reset_values("idle");

    // Normal four-entry program: three layers, 2-cycle datapath response.
    auto_en = 1'b1;
    ram[0] = 8'd4; ram[1] = 8'd3; ram[2] = 8'd8; ram[3] = 8'd5; ram[4] = 8'hFF;
    base = ls_cnt;
    apply_start();
    check_output("c1_en",   32'(bus.instr_en), 1);
    check_output("c1_addr", 32'(bus.instr_addr), 0);
    check_output("c1_busy", 32'(busy), 1);
    tick();
    check_output("c2_en",   32'(bus.instr_en), 1);
    check_output("c2_addr", 32'(bus.instr_addr), 1);
    tick();
    check_output("c3_lstart", 32'(bus.layer_start), 1);
    check_output("c3_en",     32'(bus.instr_en), 0);
    wait_done("norm", 60);
    check_output("norm_layers",  32'(ls_cnt - base), 3);
    check_output("norm_in0",     32'(ls_in[base]), 4);
    check_output("norm_out0",    32'(ls_out[base]), 3);
    check_output("norm_idx0",    32'(ls_idx[base]), 0);
    check_output("norm_in1",     32'(ls_in[base+1]), 3);
    check_output("norm_out1",    32'(ls_out[base+1]), 8);
    check_output("norm_idx1",    32'(ls_idx[base+1]), 1);
    check_output("norm_in2",     32'(ls_in[base+2]), 8);
    check_output("norm_out2",    32'(ls_out[base+2]), 5);
    check_output("norm_idx2",    32'(ls_idx[base+2]), 2);
    check_output("norm_cyc0",    32'(ls_cyc[base] - e0 + 1), 3);
    check_output("norm_cyc1",    32'(ls_cyc[base+1] - e0 + 1), 7);
    check_output("norm_cyc2",    32'(ls_cyc[base+2] - e0 + 1), 11);
    check_output("norm_donecyc", 32'(done_cyc - e0 + 1), 15);
    check_output("norm_err",     32'(err_at_done), 0);
    tick();
    check_output("norm_busy_after", 32'(busy), 0);
    check_output("norm_done_after", 32'(done), 0);

    // Marker as the very first entry.
    clear_ram();
    ram[0] = 8'hFF;
    base = ls_cnt;
    apply_start();
    wait_done("ff0", 10);
    check_output("ff0_layers",  32'(ls_cnt - base), 0);
    check_output("ff0_donecyc", 32'(done_cyc - e0 + 1), 2);
    check_output("ff0_err",     32'(err_at_done), 1);
    tick();
    check_output("ff0_err_hold", 32'(error), 1);

    // Single-entry program.
    clear_ram();
    ram[0] = 8'd4; ram[1] = 8'hFF;
    base = ls_cnt;
    apply_start();
    check_output("single_err_cleared", 32'(error), 0);
    wait_done("single", 10);
    check_output("single_layers",  32'(ls_cnt - base), 0);
    check_output("single_donecyc", 32'(done_cyc - e0 + 1), 3);
    check_output("single_err",     32'(err_at_done), 1);
    tick();

    // Zero neuron count in the second entry.
    clear_ram();
    ram[0] = 8'd4; ram[1] = 8'd0; ram[2] = 8'd3; ram[3] = 8'hFF;
    base = ls_cnt;
    apply_start();
    wait_done("zero", 10);
    check_output("zero_layers", 32'(ls_cnt - base), 0);
    check_output("zero_err",    32'(err_at_done), 1);
    tick();

    // No marker anywhere: every address holds a non-zero, non-marker value.
    for (int i = 0; i < 128; i++) ram[i] = 8'((i % 127) + 1);
    base = ls_cnt;
    apply_start();
    wait_done("nomark", 2000);
    check_output("nomark_layers",   32'(ls_cnt - base), 127);
    check_output("nomark_in125",    32'(ls_in[base+125]), 126);
    check_output("nomark_out125",   32'(ls_out[base+125]), 127);
    check_output("nomark_idx125",   32'(ls_idx[base+125]), 125);
    check_output("nomark_idx_last", 32'(ls_idx[base+126]), 126);
    check_output("nomark_err",      32'(err_at_done), 1);
    check_output("nomark_addr",     32'(addr_at_done), 127);
    tick();
    check_output("nomark_busy_after", 32'(busy), 0);

    // Stall, ignored start, ignored layer_done in ISSUE, then reset in WAIT.
    auto_en = 1'b0;
    clear_ram();
    ram[0] = 8'd4; ram[1] = 8'd3; ram[2] = 8'd8; ram[3] = 8'd5; ram[4] = 8'hFF;
    base = ls_cnt;
    dbase = done_cnt;
    apply_start();
    wait_layer_start("stall", 10);
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    check_output("stall_lstart_low", 32'(bus.layer_start), 0);
    for (int i = 0; i < 50; i++) begin
      start = (i == 10);
      tick();
      check_output("stall_in",   32'(bus.layer_in_size), 4);
      check_output("stall_out",  32'(bus.layer_out_size), 3);
      check_output("stall_busy", 32'(busy), 1);
    end
    start = 1'b0;
    check_output("stall_addr",   32'(bus.instr_addr), 1);
    check_output("stall_en",     32'(bus.instr_en), 0);
    check_output("stall_layers", 32'(ls_cnt - base), 1);
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    tick();
    check_output("l1_lstart", 32'(bus.layer_start), 1);
    check_output("l1_in",     32'(bus.layer_in_size), 3);
    check_output("l1_out",    32'(bus.layer_out_size), 8);
    check_output("l1_idx",    32'(bus.layer_index), 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("midreset");
    tick();
    check_output("midreset_no_done", 32'(done_cnt - dbase), 0);

    // Rerun after the abort starts cleanly from address 0.
    auto_en = 1'b1;
    base = ls_cnt;
    apply_start();
    check_output("rerun_addr", 32'(bus.instr_addr), 0);
    check_output("rerun_en",   32'(bus.instr_en), 1);
    wait_done("rerun", 60);
    check_output("rerun_layers", 32'(ls_cnt - base), 3);
    check_output("rerun_in0",    32'(ls_in[base]), 4);
    check_output("rerun_out0",   32'(ls_out[base]), 3);
    check_output("rerun_idx0",   32'(ls_idx[base]), 0);
    check_output("rerun_err",    32'(err_at_done), 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
